// File: rtl/branch_pc_unit_if.sv
// Bundle between the ALU/decode side and the PC unit.
// BRANCH_STATS_EN adds the branch taken / not-taken counter outputs.
`default_nettype none

interface branch_pc_unit_if;
   logic        stall;
   logic        branch;
   logic        jump;
   logic        jalr;
   logic [2:0]  funct3;
   logic        zero;
   logic        negative;
   logic        overflow;
   logic        carry;
   logic [31:0] alu_result;
   logic [31:0] imm_ext;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_valid;
   logic        taken;
   logic        trap_valid;
   logic [31:0] trap_epc;
   logic [31:0] trap_tval;
`ifdef BRANCH_STATS_EN
   logic [31:0] br_taken_cnt;
   logic [31:0] br_nt_cnt;
`endif

   modport master (
      output stall, branch, jump, jalr, funct3, zero, negative, overflow,
             carry, alu_result, imm_ext,
      input  pc, pc_plus4, fetch_valid, taken, trap_valid, trap_epc, trap_tval
`ifdef BRANCH_STATS_EN
      , input br_taken_cnt, br_nt_cnt
`endif
   );

   modport slave (
      input  stall, branch, jump, jalr, funct3, zero, negative, overflow,
             carry, alu_result, imm_ext,
      output pc, pc_plus4, fetch_valid, taken, trap_valid, trap_epc, trap_tval
`ifdef BRANCH_STATS_EN
      , output br_taken_cnt, br_nt_cnt
`endif
   );
endinterface

`default_nettype wire

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: PC register, branch/jump resolution and misaligned-target trap FSM.
// Optional macro BRANCH_STATS_EN enables the branch taken/not-taken counters.
`default_nettype none

module branch_pc_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  wire logic       clk,
   input  wire logic       rst,
   branch_pc_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_TRAP = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_fetch_valid;
   logic        r_trap_valid;
   logic [31:0] r_trap_epc;
   logic [31:0] r_trap_tval;

   logic        w_cond;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;
   logic        w_taken;
   logic        w_misaligned;

   // Flags come from A-B, so carry set means A >= B unsigned.
   always_comb begin
      w_cond = 1'b0;
      case (bus.funct3)
         3'b000:  w_cond = bus.zero;
         3'b001:  w_cond = ~bus.zero;
         3'b100:  w_cond = bus.negative ^ bus.overflow;
         3'b101:  w_cond = ~(bus.negative ^ bus.overflow);
         3'b110:  w_cond = ~bus.carry;
         3'b111:  w_cond = bus.carry;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_target     = bus.jalr ? (bus.alu_result & ~32'd1) : (r_pc + bus.imm_ext);
   assign w_taken      = r_fetch_valid & (bus.jalr | bus.jump | (bus.branch & w_cond));
   assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_BOOT;
         r_pc          <= RESET_VECTOR;
         r_fetch_valid <= 1'b0;
         r_trap_valid  <= 1'b0;
         r_trap_epc    <= 32'd0;
         r_trap_tval   <= 32'd0;
      end else begin
         case (r_state)
            S_BOOT: begin
               r_state       <= S_RUN;
               r_fetch_valid <= 1'b1;
               r_trap_valid  <= 1'b0;
            end
            S_RUN: begin
               r_trap_valid <= 1'b0;
               if (!bus.stall) begin
                  if (w_misaligned) begin
                     r_trap_epc    <= r_pc;
                     r_trap_tval   <= w_target;
                     r_trap_valid  <= 1'b1;
                     r_fetch_valid <= 1'b0;
                     r_state       <= S_TRAP;
                  end else begin
                     r_pc <= w_taken ? w_target : w_pc_plus4;
                  end
               end
            end
            S_TRAP: begin
               r_pc          <= TRAP_VECTOR;
               r_trap_valid  <= 1'b0;
               r_fetch_valid <= 1'b1;
               r_state       <= S_RUN;
            end
            default: begin
               r_state       <= S_BOOT;
               r_fetch_valid <= 1'b0;
               r_trap_valid  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc          = r_pc;
   assign bus.pc_plus4    = w_pc_plus4;
   assign bus.fetch_valid = r_fetch_valid;
   assign bus.taken       = w_taken;
   assign bus.trap_valid  = r_trap_valid;
   assign bus.trap_epc    = r_trap_epc;
   assign bus.trap_tval   = r_trap_tval;

`ifdef BRANCH_STATS_EN
   logic [31:0] r_br_taken_cnt;
   logic [31:0] r_br_nt_cnt;

   // A misaligned taken branch still counts as taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_taken_cnt <= 32'd0;
         r_br_nt_cnt    <= 32'd0;
      end else if ((r_state == S_RUN) && !bus.stall && bus.branch) begin
         if (w_cond) begin
            r_br_taken_cnt <= r_br_taken_cnt + 32'd1;
         end else begin
            r_br_nt_cnt <= r_br_nt_cnt + 32'd1;
         end
      end
   end

   assign bus.br_taken_cnt = r_br_taken_cnt;
   assign bus.br_nt_cnt    = r_br_nt_cnt;
`endif

endmodule

`default_nettype wire
